// File: rtl/vector_seq_pkg.sv
// rtl/vector_seq_pkg.sv - shared types and sizing constants for the vector op sequencer
package vector_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ALU,
    MEM
  } seq_state_t;

  localparam int VLEN_DEF  = 8;
  localparam int LANES_DEF = 2;
  localparam int GROUPS    = VLEN_DEF / LANES_DEF;
  localparam int GROUP_W   = $clog2(GROUPS);
  localparam int ELEM_W    = $clog2(VLEN_DEF);
  localparam int ALU_OP_W  = 4;
  localparam int REG_W     = 4;

endpackage

// File: rtl/vector_op_sequencer_if.sv
// rtl/vector_op_sequencer_if.sv - issue and memory handshake bundle for the sequencer
interface vector_op_sequencer_if;
  import vector_seq_pkg::*;

  logic                issue_valid;
  logic                issue_ready;
  logic                mode_sel;
  logic                mem_write;
  logic                mem_to_reg;
  logic                reg_write_v;
  logic [ALU_OP_W-1:0] alu_control;
  logic [REG_W-1:0]    rd;
  logic                mem_req;
  logic                mem_we;
  logic                mem_ack;

  modport master (
    output issue_valid, mode_sel, mem_write, mem_to_reg, reg_write_v,
           alu_control, rd, mem_ack,
    input  issue_ready, mem_req, mem_we
  );

  modport slave (
    input  issue_valid, mode_sel, mem_write, mem_to_reg, reg_write_v,
           alu_control, rd, mem_ack,
    output issue_ready, mem_req, mem_we
  );

endinterface

// File: rtl/vector_op_sequencer_beat_counter.sv
// rtl/vector_op_sequencer_beat_counter.sv - wrap counter with clear, enable and last flag
module vec_beat_counter #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         last
);

  assign last = (count == W'(MAX - 1));

  // clear dominates enable; wraps to zero after the final beat
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vector_op_sequencer.sv
// rtl/vector_op_sequencer.sv - multi-cycle issue controller for vector ALU and memory ops
module vector_op_sequencer
  import vector_seq_pkg::*;
#(
  parameter int VLEN  = VLEN_DEF,
  parameter int LANES = LANES_DEF,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  vector_op_sequencer_if.slave         bus,
  input  logic                         flush,
  output logic                         stall,
  output logic [$clog2(VLEN/LANES)-1:0] group_idx,
  output logic [$clog2(VLEN)-1:0]      elem_idx,
  output logic [ALU_OP_W-1:0]          alu_op,
  output logic                         vreg_we,
  output logic [REG_W-1:0]             vreg_waddr,
  output logic                         done,
  output logic [CNT_W-1:0]             busy_cycles
);

  localparam int GRP = VLEN / LANES;
  localparam int GW  = $clog2(GRP);
  localparam int EW  = $clog2(VLEN);

  seq_state_t          state, nextState;
  logic [ALU_OP_W-1:0] aluOpQ;
  logic [REG_W-1:0]    rdQ;
  logic                memWriteQ, memToRegQ, regWriteQ;
  logic                accept, beat, groupLast, elemLast;
  logic [CNT_W-1:0]    busyQ;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // capture the decoded control fields of an accepted vector op
  always_ff @(posedge clk) begin
    if (rst) begin
      aluOpQ    <= '0;
      rdQ       <= '0;
      memWriteQ <= 1'b0;
      memToRegQ <= 1'b0;
      regWriteQ <= 1'b0;
    end else if (accept) begin
      aluOpQ    <= bus.alu_control;
      rdQ       <= bus.rd;
      memWriteQ <= bus.mem_write;
      memToRegQ <= bus.mem_to_reg;
      regWriteQ <= bus.reg_write_v;
    end
  end

  // next-state and per-cycle strobes; flush suppresses every strobe in its cycle
  always_comb begin
    nextState   = state;
    accept      = 1'b0;
    beat        = 1'b0;
    vreg_we     = 1'b0;
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        accept = bus.issue_valid && bus.mode_sel && !flush;
        if (accept) nextState = (bus.mem_write || bus.mem_to_reg) ? MEM : ALU;
      end
      ALU: begin
        if (flush) begin
          nextState = IDLE;
        end else begin
          vreg_we = regWriteQ;
          if (groupLast) begin
            done      = 1'b1;
            nextState = IDLE;
          end
        end
      end
      MEM: begin
        if (flush) begin
          nextState = IDLE;
        end else begin
          bus.mem_req = 1'b1;
          bus.mem_we  = memWriteQ;
          beat        = bus.mem_ack;
          if (beat) begin
            // a store flag overrides a simultaneous load flag
            vreg_we = memToRegQ && !memWriteQ;
            if (elemLast) begin
              done      = 1'b1;
              nextState = IDLE;
            end
          end
        end
      end
      default: nextState = IDLE;
    endcase
  end

  vec_beat_counter #(.MAX(GRP), .W(GW)) groupCnt (
    .clk    (clk),
    .rst    (rst),
    .clear  ((state != ALU) || flush),
    .enable (state == ALU),
    .count  (group_idx),
    .last   (groupLast)
  );

  vec_beat_counter #(.MAX(VLEN), .W(EW)) elemCnt (
    .clk    (clk),
    .rst    (rst),
    .clear  ((state != MEM) || flush),
    .enable (beat),
    .count  (elem_idx),
    .last   (elemLast)
  );

  assign stall           = (state != IDLE);
  assign bus.issue_ready = (state == IDLE);
  assign alu_op          = stall ? aluOpQ : '0;
  assign vreg_waddr      = stall ? rdQ : '0;
  assign busy_cycles     = busyQ;

  // saturating count of front-end stall cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      busyQ <= '0;
    end else if (stall && (busyQ != {CNT_W{1'b1}})) begin
      busyQ <= busyQ + 1'b1;
    end
  end

endmodule
